// File: rtl/lane_stat_accum.sv
// lane_stat_accum: two-stage statistics accumulator for one Interlaken lane.
// Stage 1 registers the sum of three per-word error counts. Stage 2 adds
// that sum into a wide running counter. A level snapshot request reads
// and clears the counter in a single edge, and the addend that enters
// stage 2 on that edge is still counted.
// Optional feature: define LANE_STAT_SAT_EN to make the counter saturate
// at all ones. When it is undefined, the counter wraps.
module lane_stat_accum #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic                 snap_req,
  output logic                 snap_ack,
  output logic [CNT_WIDTH-1:0] snap_value,
  output logic                 snap_ovf,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  // Three WIDTH-bit addends need two extra bits so the sum cannot truncate.
  localparam int SW = WIDTH + 2;
  // The stage-2 sum has one extra bit, which is the carry-out used as the overflow flag.
  localparam int AW = CNT_WIDTH + 1;

  // The counter must be able to hold at least one full-scale addend.
  generate
    if (CNT_WIDTH < WIDTH + 2) begin : g_cfg_err
      $error("lane_stat_accum: CNT_WIDTH must be >= WIDTH+2");
    end
  endgenerate

  logic [SW-1:0]        in_sum;
  logic [SW-1:0]        s1;
  logic                 v1;
  logic [AW-1:0]        add;
  logic [AW-1:0]        sum;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] next_cnt;
  logic                 snap_take;

  assign in_sum = SW'(a) + SW'(b) + SW'(c);

  // Stage 1: capture the per-word sum. The valid bit is tracked every cycle.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values that were present before the edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) s1 <= in_sum;
    end
  end

  // Stage 2: form the addend, compute the sum with its carry-out, and apply the wrap or saturate rule.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    add = '0;
    if (v1) add = AW'(s1);
    sum      = {1'b0, count} + add;
    overflow = sum[CNT_WIDTH];
`ifdef LANE_STAT_SAT_EN
    next_cnt = overflow ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
`else
    next_cnt = sum[CNT_WIDTH-1:0];
`endif
  end

  // A request is accepted only when no ack is showing. This produces one-cycle acks, and a held request is retaken every other cycle.
  assign snap_take = snap_req & ~snap_ack;

  // Accumulator, sticky overflow, and the atomic snapshot-and-clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count      <= '0;
      ovf        <= 1'b0;
      snap_ack   <= 1'b0;
      snap_value <= '0;
      snap_ovf   <= 1'b0;
    end else begin
      snap_ack <= snap_take;
      if (snap_take) begin
        snap_value <= next_cnt;
        snap_ovf   <= ovf | overflow;
        count      <= '0;
        ovf        <= 1'b0;
      end else begin
        count <= next_cnt;
        ovf   <= ovf | overflow;
      end
    end
  end

endmodule

// File: tb/tb_lane_stat_accum.sv
// tb_lane_stat_accum: directed bench for lane_stat_accum (WIDTH=8, CNT_WIDTH=16).
// Each expected snapshot is queued when its request is issued. A monitor
// pops the queue on every snap_ack and compares. Live count, ovf and ack
// are checked inline by the stimulus process.
module tb_lane_stat_accum;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 16;

`ifdef LANE_STAT_SAT_EN
  localparam logic [15:0] OVF_CNT  = 16'hFFFF;
  localparam logic [15:0] OVF_CNT2 = 16'hFFFF;
`else
  localparam logic [15:0] OVF_CNT  = 16'h000E;
  localparam logic [15:0] OVF_CNT2 = 16'h000F;
`endif

  logic                 clk = 1'b0;
  logic                 arst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     a = '0;
  logic [WIDTH-1:0]     b = '0;
  logic [WIDTH-1:0]     c = '0;
  logic                 snap_req = 1'b0;
  logic                 snap_ack;
  logic [CNT_WIDTH-1:0] snap_value;
  logic                 snap_ovf;
  logic [CNT_WIDTH-1:0] count;
  logic                 ovf;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] value;
    logic                 ovf;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  lane_stat_accum #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .snap_value (snap_value),
    .snap_ovf   (snap_ovf),
    .count      (count),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] xc);
    in_valid = v;
    a = xa;
    b = xb;
    c = xc;
  endtask

  task automatic push_snap(input logic [CNT_WIDTH-1:0] v, input logic o);
    snap_t e;
    e.value = v;
    e.ovf   = o;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    snap_t e;
    if (!arst && snap_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got snap_value 0x%0h, expected no ack", snap_value);
      end else begin
        e = exp_q.pop_front();
        check("snap_value", 32'(snap_value), 32'(e.value));
        check("snap_ovf", 32'(snap_ovf), 32'(e.ovf));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Reset
    repeat (3) step();
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_ack", 32'(snap_ack), 0);
    check("rst_snap_value", 32'(snap_value), 0);
    check("rst_snap_ovf", 32'(snap_ovf), 0);
    arst = 1'b0;
    drive(1'b1, 8'd7, 8'd7, 8'd7);
    step();
    step();
    check("pre_reset_count", 32'(count), 21);
    arst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_ovf", 32'(ovf), 0);
    check("async_rst_ack", 32'(snap_ack), 0);
    drive(1'b0, 8'd7, 8'd7, 8'd7);
    step();
    arst = 1'b0;
    step();
    step();
    check("post_rst_count", 32'(count), 0);
    check("post_rst_ovf", 32'(ovf), 0);

    // 2. Full-scale add
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("fs_latency1", 32'(count), 0);
    step();
    check("fs_single", 32'(count), 765);
    push_snap(16'd765, 1'b0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    repeat (3) step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    check("fs_triple", 32'(count), 2295);
    step();
    check("fs_hold", 32'(count), 2295);

    // 3. Snapshot with data in flight
    push_snap(16'd2295, 1'b0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    drive(1'b1, 8'd100, 8'd0, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    check("inflight_base", 32'(count), 100);
    drive(1'b1, 8'd2, 8'd2, 8'd1);
    step();
    drive(1'b1, 8'd4, 8'd4, 8'd1);
    snap_req = 1'b1;
    push_snap(16'd105, 1'b0);
    step();
    check("inflight_ack", 32'(snap_ack), 1);
    check("inflight_cleared", 32'(count), 0);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    snap_req = 1'b0;
    step();
    check("inflight_count", 32'(count), 9);
    check("inflight_ack_fall", 32'(snap_ack), 0);

    // 4. Overflow
    push_snap(16'd9, 1'b0);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    repeat (85) step();
    drive(1'b1, 8'd255, 8'd240, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    check("ovf_base", 32'(count), 32'hFFF0);
    check("ovf_base_flag", 32'(ovf), 0);
    drive(1'b1, 8'd10, 8'd10, 8'd10);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    check("ovf_count", 32'(count), 32'(OVF_CNT));
    check("ovf_flag", 32'(ovf), 1);
    drive(1'b1, 8'd1, 8'd0, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    check("ovf_count2", 32'(count), 32'(OVF_CNT2));
    check("ovf_sticky", 32'(ovf), 1);
    push_snap(OVF_CNT2, 1'b1);
    snap_req = 1'b1;
    step();
    check("ovf_snap_clear_ovf", 32'(ovf), 0);
    check("ovf_snap_clear_cnt", 32'(count), 0);
    snap_req = 1'b0;
    step();

    // 5. Held request
    drive(1'b1, 8'd50, 8'd0, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    check("held_base", 32'(count), 50);
    push_snap(16'd50, 1'b0);
    push_snap(16'd3, 1'b0);
    snap_req = 1'b1;
    drive(1'b1, 8'd3, 8'd0, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("held_c1_ack", 32'(snap_ack), 1);
    step();
    check("held_c2_ack", 32'(snap_ack), 0);
    check("held_c2_count", 32'(count), 3);
    step();
    check("held_c3_ack", 32'(snap_ack), 1);
    step();
    check("held_c4_ack", 32'(snap_ack), 0);
    snap_req = 1'b0;
    step();
    check("held_c5_ack", 32'(snap_ack), 0);

    // 6. Invalid data ignored
    drive(1'b1, 8'd255, 8'd255, 8'd255);
    step();
    drive(1'b1, 8'd255, 8'd214, 8'd0);
    step();
    drive(1'b0, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("inv_base", 32'(count), 1234);
    for (int i = 0; i < 10; i++) begin
      step();
      check("inv_count", 32'(count), 1234);
      check("inv_ovf", 32'(ovf), 0);
    end

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_stat_accum.md
# lane_stat_accum

Pipelined statistics accumulator for the Interlaken lane datapath. Each valid cycle it adds three unsigned per-cycle counts (e.g. CRC errors, sync-header errors and scrambler-state mismatches for one word) into a wide running counter. A snapshot handshake atomically reads and clears the counter for the management interface without losing any in-flight increment. It sits directly downstream of the lane's error-detect logic and feeds the CSR block.

## Interface
- WIDTH, 8: width of each addend input.
- CNT_WIDTH, 32: accumulator width. Must be >= WIDTH+2; smaller values are a configuration error.
- clk  in  1  single clock; all registers are rising-edge.
- arst  in  1  asynchronous, active-high reset.
- in_valid  in  1  addends valid this cycle.
- a, b, c  in  WIDTH each  unsigned addends.
- snap_req  in  1  snapshot request, level.
- snap_ack  out  1  one-cycle pulse: snap_value and snap_ovf are updated.
- snap_value  out  CNT_WIDTH  captured counter value; held until the next snapshot.
- snap_ovf  out  1  overflow flag captured with snap_value.
- count  out  CNT_WIDTH  live accumulator value (registered).
- ovf  out  1  sticky overflow since the last snapshot or reset.

## Operation
- **Stage 1 (register):**
  - s1 <= a+b+c, computed unsigned in WIDTH+2 bits with no truncation; the maximum is 3*(2^WIDTH-1).
  - v1 <= in_valid.
  - s1 loads only when in_valid=1.
- **Stage 2 addend:** add = v1 ? s1 : 0, zero-extended to CNT_WIDTH+1 bits. sum = count + add.
- **Overflow:** occurs when sum >= 2^CNT_WIDTH.
- **Normal cycle** (no snapshot taken):
  - count <= next(sum).
  - ovf <= ovf | overflow.
- **Snapshot accepted** when snap_req=1 and snap_ack=0. On that edge:
  - snap_value <= next(sum), so the addend entering stage 2 in the same cycle is included.
  - snap_ovf <= ovf | overflow.
  - count <= 0; ovf <= 0.
  - snap_ack <= 1.
- **Ack pulse:**
  - snap_ack is high for exactly one cycle.
  - snap_req is ignored while snap_ack=1.
  - If snap_req is still high in the cycle after the ack, a new snapshot is taken.
- **next(sum):** see Configuration.
- **No valid input:** while in_valid=0 the accumulator holds. Data on a/b/c is ignored.

## Timing
- **Reset values:** every output is 0 on arst, and so are s1 and v1. Reset takes effect asynchronously and is released synchronously to clk.
- **Latency:** an input accepted at edge N is reflected in count after edge N+1, i.e. two cycles from input to count.
- **Throughput:** one addend set per cycle, with no stalls.
- **Snapshot coincident with input:** inputs present in the snapshot cycle are not lost.
  - The stage-2 addend lands in snap_value.
  - The stage-1 addend lands in the cleared count one cycle later.
- **arst mid-operation:** the in-flight s1 is discarded. A pending request is dropped and no ack is issued.
- **Overflow on a snapshot edge:** the overflow is reported in snap_ovf, and ovf stays 0.

## Configuration
- **LANE_STAT_SAT_EN defined:** next(sum) saturates. On overflow, count (or snap_value) becomes all ones, and it stays there while further additions also overflow.
- **LANE_STAT_SAT_EN undefined:** next(sum) = sum[CNT_WIDTH-1:0], i.e. the counter wraps modulo 2^CNT_WIDTH.
- In both modes ovf is set identically.

## Test plan
Bench parameters: WIDTH=8, CNT_WIDTH=16.

1. **Reset:** assert arst mid-stream with in_valid=1 and a=b=c=7 -> all outputs 0 immediately. After release with in_valid=0, count stays 0 (the in-flight 21 is discarded).
2. **Full-scale add:** a=b=c=255 for one valid cycle -> count=765 exactly two cycles later. Repeat for 3 consecutive cycles -> count=2295.
3. **Snapshot with data in flight:**
   - Setup: count=100, stage-2 addend 5, stage-1 addend 9, snap_req high for 1 cycle.
   - Result: snap_value=105, snap_ack pulses once, and count=9 the following cycle.
4. **Overflow:** count=0xFFF0, then add a=b=c=10 (30).
   - SAT_EN defined: count=0xFFFF, ovf=1.
   - SAT_EN undefined: count=0x000E, ovf=1.
   - A following snapshot gives snap_ovf=1, ovf=0.
5. **Held request:** hold snap_req high for 4 cycles -> snapshots on cycles 0 and 2. snap_ack is high on cycles 1 and 3 only.
6. **Invalid data ignored:** in_valid=0 with a=b=c=0xFF for 10 cycles -> count unchanged and ovf unchanged.
